// File: rtl/ahb_sram_wbuf_ctrl.sv
// AHB-Lite slave in front of a single-port synchronous SRAM. Writes are posted
// through a one-entry buffer; reads are zero-wait with byte forwarding from it.
module ahb_sram_wbuf_ctrl #(
    parameter int AW = 14
) (
    input  logic          cpu_clk,
    input  logic          pg_reset_b,
    input  logic          hsel,
    input  logic [31:0]   haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic [31:0]   hwdata,
    input  logic          hready,
    output logic          hreadyout,
    output logic          hresp,
    output logic [31:0]   hrdata,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [3:0]    sram_be,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_t;

    function automatic logic [3:0] f_byte_en(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            3'd0:    be = 4'b0001 << a;
            3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] f_lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] f_merge(input logic [3:0] be, input logic [31:0] buf_d,
                                            input logic [31:0] mem_d);
        return (buf_d & f_lane_mask(be)) | (mem_d & ~f_lane_mask(be));
    endfunction

    err_state_t    r_state;
    logic          r_err_rdy;
    logic          r_err_resp;
    logic          r_dp_rd;
    logic          r_dp_wr;
    logic [AW-1:0] r_dp_rd_addr;
    logic [AW-1:0] r_dp_wr_addr;
    logic [3:0]    r_dp_wr_be;
    logic          r_buf_v;
    logic [AW-1:0] r_buf_addr;
    logic [3:0]    r_buf_be;
    logic [31:0]   r_buf_data;

    logic          w_req;
    logic          w_acc;
    logic          w_illegal;
    logic          w_ill_acc;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_stall;
    logic          w_rd_go;
    logic          w_drain;
    logic          w_load;
    logic          w_fwd_hit;
    logic [3:0]    w_be;
    logic          w_unused;

    assign w_unused = ^{hburst, hprot};

    // Address-phase decode and legality
    always_comb begin
        w_req     = hsel & htrans[1];
        w_acc     = w_req & hready;
        w_be      = f_byte_en(hsize, haddr[1:0]);
        w_illegal = (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0])
                  | ((hsize == 3'd2) & (|haddr[1:0]))
                  | (|haddr[31:AW+2]);
        w_ill_acc = w_acc & w_illegal;
        w_rd_acc  = w_acc & ~w_illegal & ~hwrite;
        w_wr_acc  = w_acc & ~w_illegal & hwrite;
        // Buffer full, write data arriving and a read wanting the port: one wait state.
        // Kept independent of hready so the hready/hreadyout loop has no combinational cycle.
        w_stall   = r_dp_wr & r_buf_v & w_req & ~hwrite & ~w_illegal;
        w_rd_go   = w_rd_acc & ~w_stall;
        w_drain   = r_buf_v & ~w_rd_go;
        w_load    = r_dp_wr & ~w_stall & (~r_buf_v | w_drain);
        w_fwd_hit = r_buf_v & (r_buf_addr == r_dp_rd_addr);
    end

    // SRAM port arbitration: bus reads first, then buffer drain
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = {AW{1'b0}};
        sram_be    = 4'b0000;
        sram_wdata = 32'h0000_0000;
        if (w_rd_go) begin
            sram_cs   = 1'b1;
            sram_addr = haddr[AW+1:2];
            sram_be   = w_be;
        end else if (w_drain) begin
            sram_cs    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = r_buf_addr;
            sram_be    = r_buf_be;
            sram_wdata = r_buf_data;
        end else begin
            sram_cs = 1'b0;
        end
    end

    // Read data-phase select with forwarding from the posted write
    always_comb begin
        hrdata = 32'h0000_0000;
        if (r_dp_rd) begin
            if (w_fwd_hit) begin
                hrdata = f_merge(r_buf_be, r_buf_data, sram_rdata);
            end else begin
                hrdata = sram_rdata;
            end
        end else begin
            hrdata = 32'h0000_0000;
        end
    end

    assign hreadyout = r_err_rdy & ~w_stall;
    assign hresp     = r_err_resp;

    // Data-phase registers, advanced only when the bus completes the previous phase
    always_ff @(posedge cpu_clk or negedge pg_reset_b) begin
        if (!pg_reset_b) begin
            r_dp_rd      <= 1'b0;
            r_dp_wr      <= 1'b0;
            r_dp_rd_addr <= {AW{1'b0}};
            r_dp_wr_addr <= {AW{1'b0}};
            r_dp_wr_be   <= 4'b0000;
        end else if (hready) begin
            r_dp_rd      <= w_rd_acc;
            r_dp_wr      <= w_wr_acc;
            r_dp_rd_addr <= haddr[AW+1:2];
            r_dp_wr_addr <= haddr[AW+1:2];
            r_dp_wr_be   <= w_be;
        end
    end

    // Posted write buffer: load on write data, clear on drain
    always_ff @(posedge cpu_clk or negedge pg_reset_b) begin
        if (!pg_reset_b) begin
            r_buf_v    <= 1'b0;
            r_buf_addr <= {AW{1'b0}};
            r_buf_be   <= 4'b0000;
            r_buf_data <= 32'h0000_0000;
        end else if (w_load) begin
            r_buf_v    <= 1'b1;
            r_buf_addr <= r_dp_wr_addr;
            r_buf_be   <= r_dp_wr_be;
            r_buf_data <= hwdata & f_lane_mask(r_dp_wr_be);
        end else if (w_drain) begin
            r_buf_v <= 1'b0;
        end
    end

    // Two-cycle ERROR response sequencer with registered hreadyout/hresp
    always_ff @(posedge cpu_clk or negedge pg_reset_b) begin
        if (!pg_reset_b) begin
            r_state    <= ST_IDLE;
            r_err_rdy  <= 1'b1;
            r_err_resp <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    if (w_ill_acc) begin
                        r_state    <= ST_ERR1;
                        r_err_rdy  <= 1'b0;
                        r_err_resp <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_err_rdy  <= 1'b1;
                        r_err_resp <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    r_state    <= ST_ERR2;
                    r_err_rdy  <= 1'b1;
                    r_err_resp <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_err_rdy  <= 1'b1;
                    r_err_resp <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_wbuf_ctrl.sv
// Directed bench for ahb_sram_wbuf_ctrl: stimulus pushes expectations into
// queues, a negedge monitor pops and compares bus responses and SRAM traffic.
module tb_ahb_sram_wbuf_ctrl;

    localparam int AW = 14;
    localparam int K_RD = 0;
    localparam int K_WR = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   data;
    } wr_t;

    logic          cpu_clk;
    logic          pg_reset_b;
    logic          hsel;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [31:0]   hwdata;
    logic          hready;
    logic          hreadyout;
    logic          hresp;
    logic [31:0]   hrdata;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_be;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    int            n_checks;
    int            n_pass;
    int            n_stall;
    int            cyc;
    logic [31:0]   nxt_wd;
    rsp_t          q_rsp[$];
    wr_t           q_wr[$];
    logic [AW-1:0] q_ra[$];
    int            wr_cyc[$];
    logic [31:0]   mem[0:255];
    bit            mem_loaded;

    assign hready = hreadyout;

    ahb_sram_wbuf_ctrl #(.AW(AW)) dut (
        .cpu_clk(cpu_clk), .pg_reset_b(pg_reset_b), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata), .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_be(sram_be), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Synchronous SRAM model: preloaded once, written by byte enable, read with one cycle latency
    always @(posedge cpu_clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4]     <= 32'hDEADBEEF;
            mem[16]    <= 32'h11223344;
            mem_loaded <= 1'b1;
        end else if (sram_cs && sram_we) begin
            for (int b = 0; b < 4; b++)
                if (sram_be[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end else if (sram_cs) begin
            sram_rdata <= mem[sram_addr[7:0]];
        end
    end

    // Monitor: SRAM traffic, stall cycles and transfer completions
    initial begin
        bit   pend;
        int   age;
        logic prev_rdy;
        logic prev_resp;
        rsp_t r;
        wr_t  w;
        logic [AW-1:0] ra;
        pend = 0; age = 0; prev_rdy = 1'b1; prev_resp = 1'b0; cyc = 0;
        forever begin
            @(negedge cpu_clk);
            cyc++;
            if (!pg_reset_b) begin
                pend = 0;
                prev_rdy = 1'b1;
                prev_resp = 1'b0;
            end else begin
                if (sram_cs && sram_we) begin
                    wr_cyc.push_back(cyc);
                    if (q_wr.size() == 0) begin
                        check("sram_wr_unexpected", {32'h0, 18'h0, sram_addr}, 64'hFFFF_FFFF);
                    end else begin
                        w = q_wr.pop_front();
                        check("sram_wr", {18'h0, sram_addr, sram_be, sram_wdata},
                              {18'h0, w.addr, w.be, w.data});
                    end
                end
                if (sram_cs && !sram_we) begin
                    if (q_ra.size() == 0) begin
                        check("sram_rd_unexpected", {32'h0, 18'h0, sram_addr}, 64'hFFFF_FFFF);
                    end else begin
                        ra = q_ra.pop_front();
                        check("sram_rd_addr", {50'h0, sram_addr}, {50'h0, ra});
                    end
                end
                if (!hreadyout && !hresp) n_stall++;
                if (pend) begin
                    if (hreadyout) begin
                        pend = 0;
                        if (q_rsp.size() == 0) begin
                            check("rsp_unexpected", 64'h1, 64'h0);
                        end else begin
                            r = q_rsp.pop_front();
                            if (r.kind == K_RD)
                                check("rd_data", {31'h0, hresp, hrdata}, {32'h0, r.data});
                            else if (r.kind == K_WR)
                                check("wr_resp", {63'h0, hresp}, 64'h0);
                            else
                                check("err_seq", {60'h0, prev_rdy, prev_resp, hreadyout, hresp},
                                      64'h7);
                        end
                    end else begin
                        age++;
                        if (age > 8) begin
                            check("rsp_timeout", 64'h0, 64'h1);
                            pend = 0;
                        end
                    end
                end
                if (hsel && hready && htrans[1]) begin
                    pend = 1;
                    age = 0;
                end
                prev_rdy = hreadyout;
                prev_resp = hresp;
            end
        end
    end

    task automatic step(input bit v, input bit w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
        int n;
        hsel = v; htrans = v ? 2'b10 : 2'b00; hwrite = w; hsize = sz; haddr = a;
        hwdata = nxt_wd;
        n = 0;
        @(negedge cpu_clk);
        while (hready !== 1'b1 && n < 16) begin
            @(negedge cpu_clk);
            n++;
        end
        if (n >= 16) check("hready_wait", 64'h0, 64'h1);
        @(posedge cpu_clk);
        #1;
        nxt_wd = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        q_rsp.push_back('{K_RD, exp});
        q_ra.push_back(a[AW+1:2]);
        step(1'b1, 1'b0, 3'd2, a, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] stored, input bit drains);
        q_rsp.push_back('{K_WR, 32'h0});
        if (drains) q_wr.push_back('{a[AW+1:2], be, stored});
        step(1'b1, 1'b1, sz, a, wd);
    endtask

    task automatic err(input logic [31:0] a, input logic [2:0] sz, input bit w);
        q_rsp.push_back('{K_ERR, 32'h0});
        step(1'b1, w, sz, a, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hreadyout"}, {63'h0, hreadyout}, 64'h1);
        check({tag, "_hresp"}, {63'h0, hresp}, 64'h0);
        check({tag, "_hrdata"}, {32'h0, hrdata}, 64'h0);
        check({tag, "_sram_ctl"}, {62'h0, sram_cs, sram_we}, 64'h0);
        check({tag, "_sram_addr"}, {50'h0, sram_addr}, 64'h0);
        check({tag, "_sram_be"}, {60'h0, sram_be}, 64'h0);
        check({tag, "_sram_wdata"}, {32'h0, sram_wdata}, 64'h0);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_stall = 0; nxt_wd = 32'h0;
        pg_reset_b = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hwdata = 32'h0;
        repeat (3) @(posedge cpu_clk);
        #1;
        check_reset_outputs("por");
        pg_reset_b = 1'b1;
        idle(2);

        // Plain read
        rd(32'h0000_0010, 32'hDEADBEEF);
        idle(3);

        // Byte write then immediate read of the same word: forwarded byte 1
        wr(32'h0000_0041, 3'd0, 32'h0000_AA00, 4'b0010, 32'h0000_AA00, 1'b1);
        rd(32'h0000_0040, 32'h1122AA44);
        idle(3);
        check("no_stall_fwd", n_stall, 0);

        // Back-to-back word writes drain in consecutive cycles
        wr(32'h0, 3'd2, 32'h1111_1111, 4'hF, 32'h1111_1111, 1'b1);
        wr(32'h4, 3'd2, 32'h2222_2222, 4'hF, 32'h2222_2222, 1'b1);
        wr(32'h8, 3'd2, 32'h3333_3333, 4'hF, 32'h3333_3333, 1'b1);
        idle(4);
        check("no_stall_b2b", n_stall, 0);
        check("b2b_consecutive", wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-3], 2);

        // Buffer full + read in write data phase: exactly one wait state
        wr(32'h0, 3'd2, 32'hA0A0_A0A0, 4'hF, 32'hA0A0_A0A0, 1'b1);
        wr(32'h4, 3'd2, 32'hB0B0_B0B0, 4'hF, 32'hB0B0_B0B0, 1'b1);
        rd(32'h8, 32'h3333_3333);
        idle(4);
        check("one_stall", n_stall, 1);

        // Illegal transfers: misaligned, oversize, out of range, misaligned write
        err(32'h0000_0002, 3'd2, 1'b0);
        idle(2);
        err(32'h0000_0000, 3'd3, 1'b0);
        idle(2);
        err(32'h0001_0000, 3'd2, 1'b0);
        idle(2);
        err(32'h0000_0001, 3'd1, 1'b1);
        idle(3);
        rd(32'h0, 32'hA0A0_A0A0);
        rd(32'h4, 32'hB0B0_B0B0);
        idle(3);
        check("stall_after_err", n_stall, 1);

        // Reset while a write sits in the buffer: the write is lost
        wr(32'h80, 3'd2, 32'h5555_5555, 4'hF, 32'h5555_5555, 1'b0);
        idle(1);
        pg_reset_b = 1'b0;
        #1;
        check_reset_outputs("mid");
        @(posedge cpu_clk);
        @(posedge cpu_clk);
        #1;
        pg_reset_b = 1'b1;
        idle(3);
        rd(32'h80, 32'h0000_0000);
        idle(4);

        check("rsp_queue_empty", q_rsp.size(), 0);
        check("wr_queue_empty", q_wr.size(), 0);
        check("rd_queue_empty", q_ra.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
